param_queue: RTL and testbench

//  Parametrised circular FIFO with valid/ready handshakes on both sides.

---
 rtl/param_queue_if.sv | 37 +++
 rtl/param_queue.sv | 92 +++++++++
 tb/tb_param_queue.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/param_queue_if.sv
// param_queue_if
//   Bundles the producer-side and consumer-side handshakes of param_queue,
//   together with its flush input and status outputs.
//   slave  : the queue's view (takes in_*, flush, out_ready; drives the rest)
//   master : the environment's view (the mirror image)
// Signals
//   in_valid/in_ready/in_data     enqueue handshake and payload
//   out_valid/out_ready/out_data  dequeue handshake and head payload
//   flush                         synchronous clear of all entries
//   count                         occupancy, 0..QUEUE_DEPTH
//   almost_full                   count >= AFULL_THRESH
interface param_queue_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int QUEUE_DEPTH = 64
);
  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  flush;
  logic [CNT_W-1:0]      count;
  logic                  almost_full;

  modport slave (
    input  in_valid, in_data, out_ready, flush,
    output in_ready, out_valid, out_data, count, almost_full
  );

  modport master (
    output in_valid, in_data, out_ready, flush,
    input  in_ready, out_valid, out_data, count, almost_full
  );
endinterface

// File: rtl/param_queue.sv
// param_queue
//   Circular FIFO with valid/ready handshakes on both sides, used as the
//   instruction queue between fetch and decode/dispatch. Provides a
//   synchronous flush (branch mispredict), a registered occupancy count and
//   a registered almost-full flag.
// Ports
//   clk   : clock, all state updates on the rising edge
//   rst   : asynchronous, active-low reset
//   q     : param_queue_if.slave (handshakes, flush, count, almost_full)
module param_queue #(
  parameter int DATA_WIDTH   = 32,
  parameter int QUEUE_DEPTH  = 64,
  parameter int AFULL_THRESH = 56
) (
  input  logic          clk,
  input  logic          rst,
  param_queue_if.slave  q
);
  localparam int IDX_W = $clog2(QUEUE_DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [PTR_W-1:0] AFULL_LVL = PTR_W'(AFULL_THRESH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  // Pointers carry one extra wrap bit above the index so full and empty
  // can be told apart when the index bits match.
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [PTR_W-1:0]      r_count;
  logic                  r_afull;
  logic [DATA_WIDTH-1:0] r_mem [QUEUE_DEPTH];

  logic                  w_empty;
  logic                  w_full;
  logic                  w_enq;
  logic                  w_deq;
  logic [PTR_W-1:0]      w_count_nxt;

  assign w_empty = (r_head == r_tail);
  assign w_full  = (r_head[IDX_W-1:0] == r_tail[IDX_W-1:0]) &&
                   (r_head[IDX_W] != r_tail[IDX_W]);

  // Full blocks the enqueue even when a dequeue fires in the same cycle;
  // in_ready only rises once the freed slot is visible in the pointers.
  assign w_enq = q.in_valid  && !w_full;
  assign w_deq = q.out_ready && !w_empty;

  always_comb begin
    w_count_nxt = r_count;
    if (q.flush) begin
      w_count_nxt = '0;
    end else begin
      unique case ({w_enq, w_deq})
        2'b10:   w_count_nxt = r_count + PTR_ONE;
        2'b01:   w_count_nxt = r_count - PTR_ONE;
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // Control state: pointers, count and almost_full.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_afull <= 1'b0;
    end else begin
      if (q.flush) begin
        r_head <= '0;
        r_tail <= '0;
      end else begin
        if (w_enq) r_tail <= r_tail + PTR_ONE;
        if (w_deq) r_head <= r_head + PTR_ONE;
      end
      r_count <= w_count_nxt;
      r_afull <= (w_count_nxt >= AFULL_LVL);
    end
  end

  // Payload storage is not reset; a flushed-cycle enqueue is dropped.
  always_ff @(posedge clk) begin
    if (w_enq && !q.flush) begin
      r_mem[r_tail[IDX_W-1:0]] <= q.in_data;
    end
  end

  assign q.in_ready    = !w_full;
  assign q.out_valid   = !w_empty;
  assign q.out_data    = r_mem[r_head[IDX_W-1:0]];
  assign q.count       = r_count;
  assign q.almost_full = r_afull;
endmodule

// File: tb/tb_param_queue.sv
module tb_param_queue;
  localparam int DW    = 32;
  localparam int DEPTH = 64;
  localparam int AF    = 56;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  param_queue_if #(.DATA_WIDTH(DW), .QUEUE_DEPTH(DEPTH)) qif ();

  param_queue #(.DATA_WIDTH(DW), .QUEUE_DEPTH(DEPTH), .AFULL_THRESH(AF)) dut (
    .clk (clk),
    .rst (rst_n),
    .q   (qif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are changed and outputs sampled on the falling edge.
  task automatic idle_inputs();
    qif.in_valid  = 1'b0;
    qif.in_data   = '0;
    qif.out_ready = 1'b0;
    qif.flush     = 1'b0;
  endtask

  task automatic push_n(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      qif.in_valid = 1'b1;
      qif.in_data  = base + i;
    end
    @(negedge clk);
    qif.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (qif.out_valid !== 1'b0 || qif.in_ready !== 1'b1 || qif.count !== 0 || qif.almost_full !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_held: ov=%b ir=%b cnt=%0d af=%b required ov=0 ir=1 cnt=0 af=0",
               qif.out_valid, qif.in_ready, qif.count, qif.almost_full);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (qif.out_valid !== 1'b0 || qif.in_ready !== 1'b1 || qif.count !== 0 || qif.almost_full !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: ov=%b ir=%b cnt=%0d af=%b required ov=0 ir=1 cnt=0 af=0",
               qif.out_valid, qif.in_ready, qif.count, qif.almost_full);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      n_checks++;
      if (qif.in_ready !== 1'b1 || qif.count !== i || qif.almost_full !== (i >= AF)) begin
        n_fail++;
        $display("FAIL fill_%0d: ir=%b cnt=%0d af=%b required ir=1 cnt=%0d af=%b",
                 i, qif.in_ready, qif.count, qif.almost_full, i, (i >= AF));
      end
      qif.in_valid = 1'b1;
      qif.in_data  = 32'h1000 + i;
    end
    @(negedge clk);
    n_checks++;
    if (qif.in_ready !== 1'b0 || qif.count !== DEPTH || qif.almost_full !== 1'b1 || qif.out_data !== 32'h1000) begin
      n_fail++;
      $display("FAIL fill_full: ir=%b cnt=%0d af=%b head=%h required ir=0 cnt=64 af=1 head=00001000",
               qif.in_ready, qif.count, qif.almost_full, qif.out_data);
    end
    // 65th push is held with in_valid=1 and must be refused.
    qif.in_data = 32'hDEAD_0065;
    @(negedge clk);
    qif.in_valid = 1'b0;
    n_checks++;
    if (qif.count !== DEPTH || qif.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_overflow: cnt=%0d ir=%b required cnt=64 ir=0", qif.count, qif.in_ready);
    end
  endtask

  task automatic test_drain();
    qif.out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++;
      if (qif.out_valid !== 1'b1 || qif.out_data !== 32'h1000 + i) begin
        n_fail++;
        $display("FAIL drain_%0d: ov=%b data=%h required ov=1 data=%h",
                 i, qif.out_valid, qif.out_data, 32'h1000 + i);
      end
      @(negedge clk);
    end
    n_checks++;
    if (qif.out_valid !== 1'b0 || qif.count !== 0 || qif.almost_full !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_empty: ov=%b cnt=%0d af=%b required ov=0 cnt=0 af=0",
               qif.out_valid, qif.count, qif.almost_full);
    end
    // out_ready on an empty queue must not move the head.
    @(negedge clk);
    qif.out_ready = 1'b0;
    n_checks++;
    if (qif.count !== 0 || qif.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_deq: cnt=%0d ov=%b required cnt=0 ov=0", qif.count, qif.out_valid);
    end
  endtask

  task automatic test_simultaneous();
    push_n(5, 32'h2000);
    qif.in_valid  = 1'b1;
    qif.out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      qif.in_data = 32'h2005 + k;
      n_checks++;
      if (qif.count !== 5 || qif.out_data !== 32'h2000 + k) begin
        n_fail++;
        $display("FAIL simul_%0d: cnt=%0d data=%h required cnt=5 data=%h",
                 k, qif.count, qif.out_data, 32'h2000 + k);
      end
      @(negedge clk);
    end
    qif.in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (qif.out_valid !== 1'b1 || qif.out_data !== 32'h200A + k) begin
        n_fail++;
        $display("FAIL simul_tail_%0d: ov=%b data=%h required ov=1 data=%h",
                 k, qif.out_valid, qif.out_data, 32'h200A + k);
      end
      @(negedge clk);
    end
    qif.out_ready = 1'b0;
    n_checks++;
    if (qif.count !== 0) begin
      n_fail++;
      $display("FAIL simul_empty: cnt=%0d required 0", qif.count);
    end
  endtask

  task automatic test_full_simul();
    push_n(DEPTH, 32'h3000);
    qif.in_valid  = 1'b1;
    qif.in_data   = 32'hBEEF_0000;
    qif.out_ready = 1'b1;
    n_checks++;
    if (qif.in_ready !== 1'b0 || qif.count !== DEPTH) begin
      n_fail++;
      $display("FAIL full_simul_pre: ir=%b cnt=%0d required ir=0 cnt=64", qif.in_ready, qif.count);
    end
    @(negedge clk);
    qif.in_valid = 1'b0;
    n_checks++;
    if (qif.count !== DEPTH - 1 || qif.in_ready !== 1'b1 || qif.out_data !== 32'h3001) begin
      n_fail++;
      $display("FAIL full_simul_post: cnt=%0d ir=%b data=%h required cnt=63 ir=1 data=00003001",
               qif.count, qif.in_ready, qif.out_data);
    end
    for (int k = 1; k < DEPTH; k++) begin
      n_checks++;
      if (qif.out_valid !== 1'b1 || qif.out_data !== 32'h3000 + k) begin
        n_fail++;
        $display("FAIL full_drain_%0d: ov=%b data=%h required ov=1 data=%h",
                 k, qif.out_valid, qif.out_data, 32'h3000 + k);
      end
      @(negedge clk);
    end
    qif.out_ready = 1'b0;
    n_checks++;
    if (qif.out_valid !== 1'b0 || qif.count !== 0) begin
      n_fail++;
      $display("FAIL full_drain_empty: ov=%b cnt=%0d required ov=0 cnt=0", qif.out_valid, qif.count);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] sb[$];
    int pushed;
    int cyc;
    logic enq;
    logic deq;
    pushed = 0;
    cyc    = 0;
    while ((pushed < 300 || sb.size() != 0) && cyc < 5000) begin
      n_checks++;
      if (qif.out_valid !== (sb.size() != 0) || qif.count !== sb.size() ||
          qif.in_ready !== (sb.size() < DEPTH) ||
          (sb.size() != 0 && qif.out_data !== sb[0])) begin
        n_fail++;
        $display("FAIL wrap_cyc%0d: ov=%b ir=%b cnt=%0d data=%h required ov=%b cnt=%0d data=%h",
                 cyc, qif.out_valid, qif.in_ready, qif.count, qif.out_data,
                 (sb.size() != 0), sb.size(), (sb.size() != 0) ? sb[0] : 32'h0);
      end
      qif.in_valid  = (pushed < 300) && ($urandom_range(0, 3) != 0);
      qif.in_data   = 32'h7000_0000 + pushed;
      qif.out_ready = ($urandom_range(0, 2) != 0);
      enq = qif.in_valid && (sb.size() < DEPTH);
      deq = qif.out_ready && (sb.size() != 0);
      @(negedge clk);
      if (deq) void'(sb.pop_front());
      if (enq) begin
        sb.push_back(32'h7000_0000 + pushed);
        pushed++;
      end
      cyc++;
    end
    idle_inputs();
    n_checks++;
    if (cyc >= 5000) begin
      n_fail++;
      $display("FAIL wrap_timeout: pushed=%0d left=%0d required pushed=300 left=0", pushed, sb.size());
    end
  endtask

  task automatic test_flush();
    push_n(20, 32'h4000);
    qif.flush    = 1'b1;
    qif.in_valid = 1'b1;
    qif.in_data  = 32'hF1F1_F1F1;
    n_checks++;
    if (qif.count !== 20 || qif.out_valid !== 1'b1 || qif.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_cycle: cnt=%0d ov=%b ir=%b required cnt=20 ov=1 ir=1",
               qif.count, qif.out_valid, qif.in_ready);
    end
    @(negedge clk);
    qif.flush    = 1'b0;
    qif.in_valid = 1'b0;
    n_checks++;
    if (qif.count !== 0 || qif.out_valid !== 1'b0 || qif.in_ready !== 1'b1 || qif.almost_full !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_after: cnt=%0d ov=%b ir=%b af=%b required cnt=0 ov=0 ir=1 af=0",
               qif.count, qif.out_valid, qif.in_ready, qif.almost_full);
    end
    push_n(1, 32'h5000);
    n_checks++;
    if (qif.count !== 1 || qif.out_data !== 32'h5000) begin
      n_fail++;
      $display("FAIL flush_dropped: cnt=%0d data=%h required cnt=1 data=00005000", qif.count, qif.out_data);
    end
    qif.out_ready = 1'b1;
    @(negedge clk);
    qif.out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    push_n(10, 32'h6000);
    n_checks++;
    if (qif.count !== 10) begin
      n_fail++;
      $display("FAIL areset_pre: cnt=%0d required 10", qif.count);
    end
    qif.in_valid = 1'b1;
    qif.in_data  = 32'h6666_6666;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (qif.count !== 0 || qif.out_valid !== 1'b0 || qif.in_ready !== 1'b1 || qif.almost_full !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_mid: cnt=%0d ov=%b ir=%b af=%b required cnt=0 ov=0 ir=1 af=0",
               qif.count, qif.out_valid, qif.in_ready, qif.almost_full);
    end
    qif.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (qif.count !== 0 || qif.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_release: cnt=%0d ov=%b required cnt=0 ov=0", qif.count, qif.out_valid);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    idle_inputs();
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_full_simul();
    test_wrap();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
